aw_decoder_n: RTL and testbench

- Registered, parametrised AXI write-address decoder for one master port fanning out to NUM_S slaves.
- Per-slave base/mask address map; decoded target gets AWVALID, all slaves see the broadcast payload.
- Integrated default slave absorbs W beats of unmapped writes and returns B with DECERR.
- Drives the W-channel route select; sits between master AW port and interconnect W/B muxes.

---
 rtl/aw_decoder_n.sv | 203 ++++++++++++++++++++
 tb/tb_aw_decoder_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/aw_decoder_n.sv
// Registered AXI write-address decoder: one master AW port, NUM_S slaves plus an integrated DECERR default slave.
// Optional build macro AWDEC_FULL_TPUT_EN lets the stage accept a new AW in the same cycle it drains.
module aw_decoder_n #(
    parameter int                          NUM_S  = 2,
    parameter int                          ID_W   = 8,
    parameter int                          ADDR_W = 32,
    parameter int                          LEN_W  = 4,
    parameter int                          SIZE_W = 3,
    parameter logic [NUM_S*ADDR_W-1:0]     S_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_S*ADDR_W-1:0]     S_MASK = {32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   AWID_M,
    input  logic [ADDR_W-1:0] AWADDR_M,
    input  logic [LEN_W-1:0]  AWLEN_M,
    input  logic [SIZE_W-1:0] AWSIZE_M,
    input  logic [1:0]        AWBURST_M,
    input  logic              AWVALID_M,
    output logic              AWREADY_M,
    output logic [ID_W-1:0]   AWID_S,
    output logic [ADDR_W-1:0] AWADDR_S,
    output logic [LEN_W-1:0]  AWLEN_S,
    output logic [SIZE_W-1:0] AWSIZE_S,
    output logic [1:0]        AWBURST_S,
    output logic [NUM_S-1:0]  AWVALID_S,
    input  logic [NUM_S-1:0]  AWREADY_S,
    input  logic              WVALID_M,
    input  logic              WREADY_M,
    input  logic              WLAST_M,
    output logic [NUM_S-1:0]  WSEL,
    output logic              WSEL_DEF,
    output logic              WREADY_DEF,
    output logic [ID_W-1:0]   BID_DEF,
    output logic [1:0]        BRESP_DEF,
    output logic              BVALID_DEF,
    input  logic              BREADY_DEF
);

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_WDATA = 2'd1,
        D_BRESP = 2'd2
    } d_state_t;

    d_state_t            r_state;
    d_state_t            w_state_nxt;
    logic                r_full;
    logic                r_miss;
    logic [NUM_S-1:0]    r_hit;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [SIZE_W-1:0]   r_size;
    logic [1:0]          r_burst;
    logic                r_wbusy;
    logic [NUM_S-1:0]    r_wsel;
    logic                r_wsel_def;
    logic [ID_W-1:0]     r_bid;

    logic [NUM_S-1:0]    w_hit_sel;
    logic                w_found;
    logic                w_miss;
    logic [NUM_S-1:0]    w_awvalid_s;
    logic                w_slv_hs;
    logic                w_def_take;
    logic                w_drain;
    logic                w_awready;
    logic                w_capture;
    logic                w_wlast;
    logic                w_wready_def;
    logic                w_bvalid_def;
    logic [1:0]          w_bresp_def;

    // Priority address decode: lowest-index matching slot wins on overlap.
    always_comb begin
        w_hit_sel = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_S; i++) begin
            if (!w_found && ((AWADDR_M & S_MASK[i*ADDR_W +: ADDR_W]) == S_BASE[i*ADDR_W +: ADDR_W])) begin
                w_hit_sel[i] = 1'b1;
                w_found      = 1'b1;
            end else begin
                w_hit_sel[i] = w_hit_sel[i];
            end
        end
    end

    assign w_miss      = ~w_found;
    assign w_awvalid_s = {NUM_S{r_full & ~r_wbusy}} & r_hit;
    assign w_slv_hs    = |(w_awvalid_s & AWREADY_S);
    assign w_def_take  = r_full & r_miss & ~r_wbusy & (r_state == D_IDLE);
    assign w_drain     = w_slv_hs | w_def_take;
`ifdef AWDEC_FULL_TPUT_EN
    assign w_awready   = ~r_full | w_drain;
`else
    assign w_awready   = ~r_full;
`endif
    assign w_capture   = AWVALID_M & w_awready;
    // Default slave ends its burst on WLAST alone since it always drives WREADY_DEF.
    assign w_wlast     = r_wbusy & WVALID_M & WLAST_M & (WREADY_M | (r_state == D_WDATA));

    // Single-entry AW stage holding payload and decode result.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_full  <= 1'b0;
            r_miss  <= 1'b0;
            r_hit   <= '0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= 2'b00;
        end else if (w_capture) begin
            r_full  <= 1'b1;
            r_miss  <= w_miss;
            r_hit   <= w_hit_sel;
            r_id    <= AWID_M;
            r_addr  <= AWADDR_M;
            r_len   <= AWLEN_M;
            r_size  <= AWSIZE_M;
            r_burst <= AWBURST_M;
        end else if (w_drain) begin
            r_full  <= 1'b0;
        end else begin
            r_full  <= r_full;
        end
    end

    // W route select and single-burst-in-flight tracking.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wbusy    <= 1'b0;
            r_wsel     <= '0;
            r_wsel_def <= 1'b0;
            r_bid      <= '0;
        end else if (w_slv_hs) begin
            r_wbusy    <= 1'b1;
            r_wsel     <= r_hit;
        end else if (w_def_take) begin
            r_wbusy    <= 1'b1;
            r_wsel_def <= 1'b1;
            r_bid      <= r_id;
        end else if (w_wlast) begin
            r_wbusy    <= 1'b0;
            r_wsel     <= '0;
            r_wsel_def <= 1'b0;
        end else begin
            r_wbusy    <= r_wbusy;
        end
    end

    // Default-slave state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= D_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Default-slave next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            D_IDLE:  if (w_def_take)            w_state_nxt = D_WDATA; else w_state_nxt = D_IDLE;
            D_WDATA: if (WVALID_M && WLAST_M)   w_state_nxt = D_BRESP; else w_state_nxt = D_WDATA;
            D_BRESP: if (BREADY_DEF)            w_state_nxt = D_IDLE;  else w_state_nxt = D_BRESP;
            default: w_state_nxt = D_IDLE;
        endcase
    end

    // Default-slave outputs decoded from the registered state.
    always_comb begin
        w_wready_def = 1'b0;
        w_bvalid_def = 1'b0;
        w_bresp_def  = 2'b00;
        case (r_state)
            D_IDLE:  w_wready_def = 1'b0;
            D_WDATA: w_wready_def = 1'b1;
            D_BRESP: begin
                w_bvalid_def = 1'b1;
                w_bresp_def  = 2'b11;
            end
            default: w_wready_def = 1'b0;
        endcase
    end

    assign AWREADY_M  = w_awready;
    assign AWID_S     = r_id;
    assign AWADDR_S   = r_addr;
    assign AWLEN_S    = r_len;
    assign AWSIZE_S   = r_size;
    assign AWBURST_S  = r_burst;
    assign AWVALID_S  = w_awvalid_s;
    assign WSEL       = r_wsel;
    assign WSEL_DEF   = r_wsel_def;
    assign WREADY_DEF = w_wready_def;
    assign BID_DEF    = r_bid;
    assign BRESP_DEF  = w_bresp_def;
    assign BVALID_DEF = w_bvalid_def;

endmodule

// File: tb/tb_aw_decoder_n.sv
// Scoreboard bench for aw_decoder_n: directed AW/W/B vectors, monitor compares slave AW and default B handshakes.
module tb_aw_decoder_n;
    localparam int NUM_S = 2;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [7:0]  AWID_M = 8'h00;
    logic [31:0] AWADDR_M = 32'h0;
    logic [3:0]  AWLEN_M = 4'h0;
    logic [2:0]  AWSIZE_M = 3'd2;
    logic [1:0]  AWBURST_M = 2'b01;
    logic        AWVALID_M = 1'b0;
    logic        AWREADY_M;
    logic [7:0]  AWID_S;
    logic [31:0] AWADDR_S;
    logic [3:0]  AWLEN_S;
    logic [2:0]  AWSIZE_S;
    logic [1:0]  AWBURST_S;
    logic [1:0]  AWVALID_S;
    logic [1:0]  AWREADY_S = 2'b11;
    logic        WVALID_M = 1'b0;
    logic        WREADY_M = 1'b1;
    logic        WLAST_M = 1'b0;
    logic [1:0]  WSEL;
    logic        WSEL_DEF;
    logic        WREADY_DEF;
    logic [7:0]  BID_DEF;
    logic [1:0]  BRESP_DEF;
    logic        BVALID_DEF;
    logic        BREADY_DEF = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [50:0] aw_q[$];
    logic [9:0]  b_q[$];
    logic [50:0] prev_aw;
    logic        prev_pend = 1'b0;
`ifdef AWDEC_FULL_TPUT_EN
    logic exp_tput = 1'b1;
`else
    logic exp_tput = 1'b0;
`endif

    aw_decoder_n dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WVALID_M(WVALID_M), .WREADY_M(WREADY_M), .WLAST_M(WLAST_M),
        .WSEL(WSEL), .WSEL_DEF(WSEL_DEF), .WREADY_DEF(WREADY_DEF),
        .BID_DEF(BID_DEF), .BRESP_DEF(BRESP_DEF), .BVALID_DEF(BVALID_DEF), .BREADY_DEF(BREADY_DEF)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on slave AW and default B handshakes; checks AW hold stability.
    always @(negedge ACLK) begin
        logic [50:0] cur;
        cur = {AWVALID_S, AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S};
        if (!ARESETn) begin
            prev_pend <= 1'b0;
        end else begin
            if (prev_pend) check("aw_stable", {13'd0, cur}, {13'd0, prev_aw});
            if (|(AWVALID_S & AWREADY_S)) begin
                if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
                else check("aw_handshake", {13'd0, cur}, {13'd0, aw_q.pop_front()});
            end
            if (BVALID_DEF && BREADY_DEF) begin
                if (b_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
                else check("b_handshake", {54'd0, BID_DEF, BRESP_DEF}, {54'd0, b_q.pop_front()});
            end
            prev_pend <= (|AWVALID_S) && !(|(AWVALID_S & AWREADY_S));
            prev_aw   <= cur;
        end
    end

    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] vec, input logic is_miss, input logic push);
        int t;
        if (push) begin
            if (is_miss) b_q.push_back({id, 2'b11});
            else aw_q.push_back({vec, id, addr, len, 3'd2, 2'b01});
        end
        AWID_M = id; AWADDR_M = addr; AWLEN_M = len; AWVALID_M = 1'b1;
        t = 0;
        @(negedge ACLK);
        while (!AWREADY_M && t < 40) begin
            @(negedge ACLK);
            t++;
        end
        if (!AWREADY_M) check("aw_accept_timeout", 64'd0, 64'd1);
        @(posedge ACLK); #1;
        AWVALID_M = 1'b0;
    endtask

    task automatic w_send(input int n, input logic [1:0] exp_sel, input logic exp_def);
        for (int k = 0; k < n; k++) begin
            WVALID_M = 1'b1;
            WLAST_M  = (k == n - 1);
            @(negedge ACLK);
            check("w_route", {58'd0, WSEL, WSEL_DEF, AWVALID_S, BVALID_DEF}, {58'd0, exp_sel, exp_def, 2'b00, 1'b0});
            check("w_def_ready", {63'd0, WREADY_DEF}, {63'd0, exp_def});
            @(posedge ACLK); #1;
        end
        WVALID_M = 1'b0;
        WLAST_M  = 1'b0;
        @(negedge ACLK);
        check("w_release", {61'd0, WSEL, WSEL_DEF}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {AWREADY_M, AWVALID_S, WSEL, WSEL_DEF, WREADY_DEF, BVALID_DEF, BRESP_DEF, BID_DEF, AWADDR_S},
              {1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 32'h0});
    endtask

    initial begin
        #22 ARESETn = 1'b1;
        @(negedge ACLK);
        check_reset_outputs("reset_values");
        @(posedge ACLK); #1;

        // Hit S0, 4-beat burst
        aw_send(8'h11, 32'h0000_1234, 4'd3, 2'b01, 1'b0, 1'b1);
        @(negedge ACLK);
        check("s0_first_valid", {30'd0, AWVALID_S, AWADDR_S}, {30'd0, 2'b01, 32'h0000_1234});
        check("drain_cycle_ready", {63'd0, AWREADY_M}, {63'd0, exp_tput});
        @(posedge ACLK); #1;
        w_send(4, 2'b01, 1'b0);
        @(posedge ACLK); #1;

        // Hit S1 with slave stalling for 5 cycles
        AWREADY_S = 2'b01;
        aw_send(8'h22, 32'h0001_0000, 4'd0, 2'b10, 1'b0, 1'b1);
        repeat (5) begin
            @(negedge ACLK);
            check("s1_stall", {21'd0, AWVALID_S, AWID_S, AWADDR_S, AWREADY_M}, {21'd0, 2'b10, 8'h22, 32'h0001_0000, 1'b0});
            @(posedge ACLK); #1;
        end
        AWREADY_S = 2'b11;
        @(posedge ACLK); #1;
        w_send(1, 2'b10, 1'b0);
        @(posedge ACLK); #1;

        // Unmapped write to default slave
        aw_send(8'h25, 32'h0002_0000, 4'd1, 2'b00, 1'b1, 1'b1);
        @(posedge ACLK); #1;
        w_send(2, 2'b00, 1'b1);
        @(posedge ACLK); #1;
        repeat (3) begin
            @(negedge ACLK);
            check("b_hold", {51'd0, BVALID_DEF, BID_DEF, BRESP_DEF, AWVALID_S}, {51'd0, 1'b1, 8'h25, 2'b11, 2'b00});
            @(posedge ACLK); #1;
        end
        BREADY_DEF = 1'b1;
        @(posedge ACLK); #1;
        BREADY_DEF = 1'b0;
        @(negedge ACLK);
        check("b_done", {62'd0, BVALID_DEF, WREADY_DEF}, 64'd0);
        @(posedge ACLK); #1;

        // Ordering: S1 AW must wait for S0 WLAST
        aw_send(8'h31, 32'h0000_0040, 4'd1, 2'b01, 1'b0, 1'b1);
        aw_send(8'h32, 32'h0001_0080, 4'd0, 2'b10, 1'b0, 1'b1);
        w_send(2, 2'b01, 1'b0);
        check("order_release", {62'd0, AWVALID_S}, {62'd0, 2'b10});
        @(posedge ACLK); #1;
        w_send(1, 2'b10, 1'b0);
        @(posedge ACLK); #1;

        // Short sequence of S0 single-beat writes
        for (int k = 0; k < 3; k++) begin
            aw_send(8'h50 + 8'(k), 32'(k) * 32'h100, 4'd0, 2'b01, 1'b0, 1'b1);
            @(posedge ACLK); #1;
            w_send(1, 2'b01, 1'b0);
            @(posedge ACLK); #1;
        end

        // Reset during default-slave W data
        aw_send(8'h44, 32'h0003_0000, 4'd2, 2'b00, 1'b1, 1'b0);
        @(posedge ACLK); #1;
        WVALID_M = 1'b1;
        WLAST_M  = 1'b0;
        @(negedge ACLK);
        check("def_wdata", {62'd0, WREADY_DEF, WSEL_DEF}, {62'd0, 2'b11});
        @(posedge ACLK); #2;
        ARESETn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        WVALID_M = 1'b0;
        @(posedge ACLK);
        @(posedge ACLK); #2;
        ARESETn = 1'b1;
        repeat (4) begin
            @(negedge ACLK);
            check("post_reset", {61'd0, BVALID_DEF, AWREADY_M, WREADY_DEF}, {61'd0, 3'b010});
        end

        check("aw_queue_empty", 64'(aw_q.size()), 64'd0);
        check("b_queue_empty", 64'(b_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
